// File: rtl/dmar_addr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmar_addr_sequencer
// Purpose  : Walks an IMG_W x IMG_H input image in 2x2 windows and emits the
//            data-memory word address of every input pixel. Within a window
//            the order is (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1). The
//            column index j advances fastest and the row index i slowest.
//            A valid/ready handshake paces the output. Addresses wrap modulo
//            2^19 and are built incrementally from row-base and column
//            pointers, so no multiplier is used.
// Ports    : clk         - clock; all state updates on the rising edge
//            RST         - synchronous active-high reset
//            start       - single-cycle request to begin one pass
//            addr_ready  - consumer accepts addr_out this cycle
//            addr_out    - current data-memory address (19 bits)
//            addr_valid  - addr_out holds a valid address
//            dmar_en     - 4'b0001 on a transfer cycle, else 4'b0000
//            tap         - window position of addr_out (0..3)
//            busy        - pass in progress
//            done        - one-cycle pulse after the final address is taken
// Revision : 1.0 - initial release
// ============================================================================
module dmar_addr_sequencer #(
  parameter int          IMG_W = 256,
  parameter int          IMG_H = 256,
  parameter logic [18:0] BASE  = 19'h00000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        addr_ready,
  output logic [18:0] addr_out,
  output logic        addr_valid,
  output logic [3:0]  dmar_en,
  output logic [1:0]  tap,
  output logic        busy,
  output logic        done
);

  // Pointer steps, all reduced to the 19-bit address space.
  localparam logic [18:0] c_row_step  = 19'(IMG_W);       // one input row
  localparam logic [18:0] c_pair_step = 19'(2 * IMG_W);   // two input rows
  localparam logic [18:0] c_down_step = 19'(IMG_W - 1);   // tap 1 -> tap 2
  localparam logic [18:0] c_last_col  = 19'(IMG_W - 2);   // column of last window
  localparam logic [18:0] c_last_row  = 19'(IMG_H - 2);   // row of last window

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Initialisers give the reset values at power-up on targets that honour them.
  state_t      r_state    = ST_IDLE;
  logic [18:0] r_addr     = 19'h00000;
  logic [1:0]  r_tap      = 2'd0;
  logic        r_valid    = 1'b0;
  logic        r_busy     = 1'b0;
  logic        r_done     = 1'b0;
  logic [18:0] r_row_base = 19'h00000;  // address of input row 2i, column 0
  logic [18:0] r_col      = 19'h00000;  // column offset 2j of current window
  logic [18:0] r_row      = 19'h00000;  // row offset 2i of current window

  logic        w_xfer;
  logic        w_last_col;
  logic        w_last_row;
  logic [18:0] w_col_next;
  logic [18:0] w_row_base_next;

  // r_valid is only ever set in EMIT, so a transfer needs no state decode.
  assign w_xfer          = r_valid & addr_ready;
  assign w_last_col      = (r_col == c_last_col);
  assign w_last_row      = (r_row == c_last_row);
  assign w_col_next      = r_col + 19'd2;
  assign w_row_base_next = r_row_base + c_pair_step;

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_addr     <= 19'h00000;
      r_tap      <= 2'd0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_row_base <= 19'h00000;
      r_col      <= 19'h00000;
      r_row      <= 19'h00000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= ST_EMIT;
            r_valid    <= 1'b1;
            r_busy     <= 1'b1;
            r_addr     <= BASE;
            r_tap      <= 2'd0;
            r_row_base <= BASE;
            r_col      <= 19'h00000;
            r_row      <= 19'h00000;
          end
        end

        ST_EMIT: begin
          if (w_xfer) begin
            case (r_tap)
              2'd0: begin
                r_addr <= r_addr + 19'd1;
                r_tap  <= 2'd1;
              end
              2'd1: begin
                // Step down one row and back one column.
                r_addr <= r_addr + c_down_step;
                r_tap  <= 2'd2;
              end
              2'd2: begin
                r_addr <= r_addr + 19'd1;
                r_tap  <= 2'd3;
              end
              default: begin
                if (w_last_col && w_last_row) begin
                  // Final transfer: address and tap hold their last value.
                  r_state <= ST_DONE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else if (w_last_col) begin
                  r_row_base <= w_row_base_next;
                  r_addr     <= w_row_base_next;
                  r_col      <= 19'h00000;
                  r_row      <= r_row + 19'd2;
                  r_tap      <= 2'd0;
                end else begin
                  r_col  <= w_col_next;
                  r_addr <= r_row_base + w_col_next;
                  r_tap  <= 2'd0;
                end
              end
            endcase
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out   = r_addr;
  assign addr_valid = r_valid;
  assign tap        = r_tap;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dmar_en    = {3'b000, w_xfer};

endmodule
`default_nettype wire

// File: doc/dmar_addr_sequencer.md
DMAR_ADDR_SEQUENCER -- requirements
Module: dmar_addr_sequencer

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- IMG_W, 256, input image width in pixels; even, >= 2.
- IMG_H, 256, input image height in pixels; even, >= 2.
- BASE, 19'h00000, byte-free word address of input pixel (0,0).

REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, input, 1, clock; all state updates on rising edge.
- RST, input, 1, reset; synchronous, active-high.
- start, input, 1, single-cycle request to begin one downsampling address pass.
- addr_ready, input, 1, consumer (DMAR/memory) accepts addr_out this cycle.
- addr_out, output, 19, current data-memory address.
- addr_valid, output, 1, addr_out holds a valid address.
- dmar_en, output, 4, DMAR load code: 4'b0001 when addr_valid & addr_ready, else 4'b0000.
- tap, output, 2, window position of addr_out: 0=(2i,2j), 1=(2i,2j+1), 2=(2i+1,2j), 3=(2i+1,2j+1).
- busy, output, 1, pass in progress.
- done, output, 1, one-cycle pulse after final address is accepted.

Function
REQ-003 FSM SHALL have states IDLE, EMIT, DONE.
REQ-004 IDLE: start=1 -> EMIT next cycle; start=0 -> stay IDLE.
REQ-005 EMIT: addr_valid=1, busy=1; on the last transfer (i=IMG_H/2-1, j=IMG_W/2-1, tap=3) -> DONE.
REQ-006 DONE: done=1, busy=0, addr_valid=0 for exactly one cycle, then IDLE.
REQ-007 Per output pixel (i,j), the four taps SHALL be emitted in order 0,1,2,3; j SHALL increment fastest, i slowest.
REQ-008 Address SHALL equal (BASE + r*IMG_W + c) mod 2^19, where r,c are the tap's input row and column; truncation to 19 bits implies wrap from 19'h7FFFF to 19'h00000.
REQ-009 Addresses SHALL be generated incrementally: row-base and column pointers; no multiplier.
REQ-010 Transfer occurs only on cycles where addr_valid=1 and addr_ready=1; tap/address advance only on a transfer.
REQ-011 With addr_valid=1 and addr_ready=0, addr_out and tap SHALL hold stable.
REQ-012 Throughput SHALL be one address per cycle while addr_ready is held high.
REQ-013 Latency: start sampled in IDLE at edge N -> first address valid at output after edge N+1.
REQ-014 A pass SHALL produce exactly IMG_W*IMG_H transfers.
REQ-015 start SHALL be ignored in EMIT and DONE.
REQ-016 dmar_en SHALL be combinationally decoded from addr_valid & addr_ready.
REQ-017 Outside EMIT, addr_out SHALL hold its last value, and tap SHALL hold its last value.

Reset
REQ-018 RST=1 at a clock edge SHALL force IDLE, with addr_out=19'b0, tap=0, addr_valid=0, busy=0, done=0, dmar_en=4'b0000; all internal counters SHALL be cleared.
REQ-019 RST SHALL take priority over start and over an in-flight transfer; a pass interrupted by reset SHALL NOT resume.
REQ-020 Outputs SHALL also be initialised to the reset values at power-up.

Verification
REQ-021 IMG_W=4, IMG_H=4, BASE=0, ready=1, start pulse -> addresses 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15 on 16 consecutive cycles; done pulses the next cycle; dmar_en=4'b0001 on each transfer.
REQ-022 Same setup, ready=0 for 3 cycles while addr_out=4 -> addr_out=4, tap=2, dmar_en=4'b0000 held; sequence resumes with 5 when ready returns.
REQ-023 BASE=19'h7FFFE, IMG_W=2, IMG_H=2 -> addresses 7FFFE, 7FFFF, 00000, 00001, then done.
REQ-024 RST asserted after the 6th transfer -> next cycle in IDLE with addr_out=0 and busy=0; a new start restarts from address BASE.
REQ-025 start pulsed mid-pass and during DONE -> no effect; transfer count stays 16 and there is a single done pulse.
REQ-026 start and RST high in the same cycle -> stays IDLE, addr_valid=0.
